lsu_ex_wb_pipe: RTL
===================

Name: lsu_ex_wb_pipe

Overview:
Parametrised EX->WB pipeline stage for the LSU. It carries a full VLIW bundle of LANES load/store slots as one unit. Control is a valid/ready handshake with a 2-entry skid buffer, so writeback back-pressure never creates a combinational path from out_ready to in_ready. It adds flush, NOP fill on empty, per-lane writeback enables and an occupancy count.

Parameters:
LANES, 4, number of LSU slots per bundle (>=1)
REG_W, 5, register index width
SIZE_W, 2, access size code width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
flush  in  1  synchronous bundle kill, highest priority
in_valid  in  1  EX bundle valid
in_ready  out  1  stage can accept; registered, equals ~skid_valid
is_load_in  in  LANES  per-lane load flag
zero_ext_in  in  LANES  per-lane zero-extend (1) / sign-extend (0)
is_nop_in  in  LANES  per-lane NOP flag
size_in  in  LANES*SIZE_W  per-lane size; lane i at [i*SIZE_W +: SIZE_W]
rd_in  in  LANES*REG_W  per-lane destination; lane i at [i*REG_W +: REG_W]
out_valid  out  1  WB bundle valid
out_ready  in  1  WB consumes bundle
is_load_out, zero_ext_out, is_nop_out  out  LANES  head-entry fields
size_out  out  LANES*SIZE_W  head-entry sizes
rd_out  out  LANES*REG_W  head-entry destinations
wb_en  out  LANES  out_valid & is_load_out[i] & ~is_nop_out[i] & (rd_out[i] != 0)
occupancy  out  2  entries held (0..2)

Behaviour:
- Storage: head entry (drives outputs) and skid entry, each with a valid bit and a full bundle.
- NOP bundle: is_nop=all 1; is_load, zero_ext, size, rd = 0.
- Reset (rst=0, async): head_valid=0, skid_valid=0, head=NOP bundle, skid=NOP bundle. Resulting outputs: out_valid=0, in_ready=1, is_nop_out all 1, all other outputs 0, wb_en=0, occupancy=0.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Per clock, in priority order:
  1. flush: both valid bits cleared, head loaded with NOP bundle. Any in-beat or pop in the same cycle is discarded.
  2. pop & skid_valid: head<=skid, skid_valid<=0. Accept cannot occur because in_ready=0.
  3. accept & (~head_valid | pop): head<=input bundle, head_valid<=1.
  4. accept & head_valid & ~pop: skid<=input bundle, skid_valid<=1.
  5. pop & ~accept & ~skid_valid: head_valid<=0, head<=NOP bundle.
  6. Otherwise hold.
- Latency: 1 cycle from accept into an empty stage to out_valid=1. Full throughput of 1 bundle/cycle while out_ready=1.
- Head contents are stable while out_valid & ~out_ready; no field changes until pop or flush.
- in_ready is a pure flop output; no combinational path from out_ready or in_valid.
- occupancy = head_valid + skid_valid. head_valid=0 implies skid_valid=0.
- Lanes are bundle-atomic; there is no per-lane handshake. A lane with is_nop_in=1 still travels in its slot.
- wb_en is combinational from the head entry only. rd=0 never enables writeback.
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold rst=0 with random inputs -> out_valid=0, in_ready=1, is_nop_out=4'b1111, rd_out=0, wb_en=0, occupancy=0. Release rst -> state unchanged until a bundle is accepted.
- Streaming: out_ready=1, 8 back-to-back bundles with lane0 rd=1..8 -> each appears exactly one cycle after accept, in order, no bubbles, occupancy stays 1.
- Back-pressure: out_ready=0, send A then B -> in_ready drops to 0 after B, occupancy=2, outputs show A. Raise out_ready -> A then B delivered, in_ready=1 the cycle after A pops.
- wb_en: one bundle with lanes {load rd=3, load rd=0, store rd=7, load+nop rd=9} -> wb_en=4'b0001.
- Flush: with occupancy=2 and in_valid=1, pulse flush -> next cycle occupancy=0, out_valid=0, is_nop_out=all 1, in_ready=1. No flushed bundle is ever popped.
- Reset mid-stall: occupancy=2, drive rst=0 between clock edges -> outputs go to reset values immediately. After release, the first accepted bundle is the only one delivered.

Source files
------------

// File: rtl/lsu_ex_wb_pipe.sv
// EX->WB pipeline stage for the LSU: carries a whole VLIW bundle of LANES slots
// behind a valid/ready handshake with a 2-entry skid buffer and a flush.
module lsu_ex_wb_pipe #(
    parameter int LANES  = 4,
    parameter int REG_W  = 5,
    parameter int SIZE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          is_load_in,
    input  logic [LANES-1:0]          zero_ext_in,
    input  logic [LANES-1:0]          is_nop_in,
    input  logic [LANES*SIZE_W-1:0]   size_in,
    input  logic [LANES*REG_W-1:0]    rd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          is_load_out,
    output logic [LANES-1:0]          zero_ext_out,
    output logic [LANES-1:0]          is_nop_out,
    output logic [LANES*SIZE_W-1:0]   size_out,
    output logic [LANES*REG_W-1:0]    rd_out,
    output logic [LANES-1:0]          wb_en,
    output logic [1:0]                occupancy
);

    logic                     r_head_valid;
    logic                     r_skid_valid;
    logic                     r_in_ready;
    logic [LANES-1:0]         r_head_load, r_head_zext, r_head_nop;
    logic [LANES*SIZE_W-1:0]  r_head_size;
    logic [LANES*REG_W-1:0]   r_head_rd;
    logic [LANES-1:0]         r_skid_load, r_skid_zext, r_skid_nop;
    logic [LANES*SIZE_W-1:0]  r_skid_size;
    logic [LANES*REG_W-1:0]   r_skid_rd;
    logic                     w_accept;
    logic                     w_pop;
    logic [LANES-1:0]         w_wb_en;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_head_valid & out_ready;

    // in_ready is its own flop, kept equal to ~skid_valid, so out_ready never reaches it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_head_load  <= '0;
            r_head_zext  <= '0;
            r_head_nop   <= '1;
            r_head_size  <= '0;
            r_head_rd    <= '0;
            r_skid_load  <= '0;
            r_skid_zext  <= '0;
            r_skid_nop   <= '1;
            r_skid_size  <= '0;
            r_skid_rd    <= '0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_head_load  <= '0;
            r_head_zext  <= '0;
            r_head_nop   <= '1;
            r_head_size  <= '0;
            r_head_rd    <= '0;
        end else if (w_pop && r_skid_valid) begin
            r_head_load  <= r_skid_load;
            r_head_zext  <= r_skid_zext;
            r_head_nop   <= r_skid_nop;
            r_head_size  <= r_skid_size;
            r_head_rd    <= r_skid_rd;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_accept && (!r_head_valid || w_pop)) begin
            r_head_load  <= is_load_in;
            r_head_zext  <= zero_ext_in;
            r_head_nop   <= is_nop_in;
            r_head_size  <= size_in;
            r_head_rd    <= rd_in;
            r_head_valid <= 1'b1;
        end else if (w_accept) begin
            r_skid_load  <= is_load_in;
            r_skid_zext  <= zero_ext_in;
            r_skid_nop   <= is_nop_in;
            r_skid_size  <= size_in;
            r_skid_rd    <= rd_in;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else if (w_pop) begin
            r_head_valid <= 1'b0;
            r_head_load  <= '0;
            r_head_zext  <= '0;
            r_head_nop   <= '1;
            r_head_size  <= '0;
            r_head_rd    <= '0;
        end
    end

    always_comb begin
        w_wb_en = '0;
        for (int i = 0; i < LANES; i++) begin
            w_wb_en[i] = r_head_valid & r_head_load[i] & ~r_head_nop[i] &
                         (r_head_rd[i*REG_W +: REG_W] != '0);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_head_valid;
    assign is_load_out  = r_head_load;
    assign zero_ext_out = r_head_zext;
    assign is_nop_out   = r_head_nop;
    assign size_out     = r_head_size;
    assign rd_out       = r_head_rd;
    assign wb_en        = w_wb_en;
    assign occupancy    = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

endmodule
